act_backward_sign: RTL and testbench
====================================

# act_backward_sign

Streaming backward-pass unit for the signed fixed-point activation library: for each element it computes the input gradient dx = dy · f'(x) for ReLU, leaky ReLU, hardtanh and sigmoid. It sits after the layer's gradient source and before the weight-update/backprop datapath, mirroring the forward activation blocks. It processes one element per cycle through a 3-stage pipeline with valid/ready handshaking and full backpressure.

## Interface
- WIDTH, 8: total bits, 1 sign + WIDTH-1 data, two's complement.
- DECIMAL_POINT, 5: fraction bits; ONE = 1 <<< DECIMAL_POINT.
- NEGATIVE_SLOPE_SHIFT, 5: leaky slope = 2^-SHIFT; must be ≤ DECIMAL_POINT (elaboration check).
- CNT_WIDTH, 16: width of the output beat counter.

Ports:
- iClk  in  1  clock.
- iRst  in  1  reset, synchronous, active-low.
- mode  in  2  activation select: 0 relu, 1 leakyRelu, 2 hardtanh, 3 sigmoid. Sampled with the beat.
- xIn  in  WIDTH signed  forward-pass input x; for sigmoid, the forward output y.
- gIn  in  WIDTH signed  upstream gradient dy.
- lastIn  in  1  end-of-tensor marker, passed through.
- inValid  in  1  input beat valid.
- inReady  out  1  unit accepts the beat this cycle.
- gOut  out  WIDTH signed  gradient dx.
- lastOut  out  1  marker aligned with gOut.
- outValid  out  1  gOut is valid.
- outReady  in  1  consumer accepts.
- beatCount  out  CNT_WIDTH  number of output beats accepted since reset; wraps.

## Operation
- Beat accepted when inValid && inReady; delivered when outValid && outReady.
- Stage 1 (factor): register g and last; compute the derivative factor F in Q(DECIMAL_POINT):
  - relu: F = ONE if x[WIDTH-1] == 0 (x = 0 included), else 0.
  - leakyRelu: F = ONE if x ≥ 0, else ONE >>> NEGATIVE_SLOPE_SHIFT.
  - hardtanh: F = ONE if -ONE ≤ x ≤ ONE (inclusive), else 0.
  - sigmoid: clamp y to [0, ONE]; F = (y · (ONE − y)) >>> DECIMAL_POINT, computed at full 2·WIDTH precision.
- Stage 2: P = g · F, a signed 2·WIDTH-bit product.
- Stage 3: R = P >>> DECIMAL_POINT (arithmetic shift, truncation toward −inf). Saturate R to [−2^(WIDTH−1), 2^(WIDTH−1)−1], then register it to gOut.
- Mode is carried per beat. Mixed modes in flight are legal and must not interfere.
- beatCount increments on each output handshake and wraps at 2^CNT_WIDTH.

## Timing
- Reset, when iRst = 0 at a clock edge: all stage valids = 0, outValid = 0, gOut = 0, lastOut = 0, beatCount = 0, inReady = 0 during that cycle. Beats in flight are discarded.
- Latency is 3 cycles for every mode: a beat accepted at edge n is presented at edge n+3 if no stall occurs.
- Throughput is 1 beat/cycle.
- Stall rule: advance = !outValid || outReady. All stages move together when advance = 1 and hold when advance = 0.
- inReady = advance && iRst. Combinational from outReady; no combinational path from inValid.
- gOut and lastOut hold stable while outValid && !outReady.
- When an output handshake and an input handshake occur in the same cycle, both complete and the pipeline stays full.
- Bubbles propagate as invalid stages.

## Structure
- Shared package: mode encoding constants (ACT_RELU, ACT_LEAKY, ACT_HARDTANH, ACT_SIGMOID) and the ONE/−ONE fixed-point helper constants. The forward library uses the same package.
- Natural sub-module: act_deriv_factor, the combinational stage-1 factor computation for all modes. The pipeline and handshake logic live in the top.

## Test plan
All scenarios use WIDTH=8, DECIMAL_POINT=5, ONE=32.
- relu: (x=−3, g=40) → 0; (x=0, g=40) → 40. Each appears exactly 3 cycles after acceptance.
- leakyRelu, SHIFT=5: (x=−1, g=64) → 2; (x=−1, g=−64) → −2; (x=5, g=−64) → −64.
- hardtanh: x = 32, −32, 33, −33, each with g=20 → outputs 20, 20, 0, 0.
- sigmoid: (y=16, g=32) → F=8 → 8; (y=0, g=100) → 0; (y=40, clamped to 32) → 0.
- Backpressure: stream 6 beats back-to-back, hold outReady low for 4 cycles mid-stream. Expect inReady low while stalled, no loss or duplication, order preserved, gOut stable, beatCount=6 at the end, and lastOut only on beat 6.
- Reset mid-stream with 3 beats in flight: one cycle later outValid=0 and beatCount=0, and none of the old beats ever emerge.

Source files
------------

// File: rtl/act_backward_sign_pkg.sv
// Shared definitions for the signed fixed-point activation library (forward and backward blocks).
// Holds the activation mode encoding and the fixed-point unit helpers.
package act_backward_sign_pkg;

    typedef enum logic [1:0] {
        ACT_RELU     = 2'd0,
        ACT_LEAKY    = 2'd1,
        ACT_HARDTANH = 2'd2,
        ACT_SIGMOID  = 2'd3
    } act_mode_e;

    // +1.0 and -1.0 in a Q format with decimal_point fraction bits.
    function automatic int fx_one(input int decimal_point);
        return 1 << decimal_point;
    endfunction

    function automatic int fx_neg_one(input int decimal_point);
        return -(1 << decimal_point);
    endfunction

endpackage

// File: rtl/act_backward_sign_deriv_factor.sv
// Combinational derivative factor f'(x) in Q(DECIMAL_POINT) for every supported activation.
// For sigmoid the input is the forward output y, and f'(y) = y * (1 - y).
module act_deriv_factor
    import act_backward_sign_pkg::*;
#(
    parameter int WIDTH                = 8,
    parameter int DECIMAL_POINT        = 5,
    parameter int NEGATIVE_SLOPE_SHIFT = 5
) (
    input  act_mode_e                 mode,
    input  logic signed [WIDTH-1:0]   x,
    output logic signed [WIDTH:0]     factor
);

    localparam int FW = WIDTH + 1;
    localparam int PW = 2 * WIDTH;

    localparam logic signed [FW-1:0] ONE_F     = FW'(fx_one(DECIMAL_POINT));
    localparam logic signed [FW-1:0] LEAK_F    = FW'(fx_one(DECIMAL_POINT) >>> NEGATIVE_SLOPE_SHIFT);
    localparam logic signed [PW-1:0] ONE_P     = PW'(fx_one(DECIMAL_POINT));
    localparam logic signed [PW-1:0] NEG_ONE_P = PW'(fx_neg_one(DECIMAL_POINT));

    if (NEGATIVE_SLOPE_SHIFT < 0 || NEGATIVE_SLOPE_SHIFT > DECIMAL_POINT) begin : g_bad_slope
        $error("act_deriv_factor: NEGATIVE_SLOPE_SHIFT must lie in [0, DECIMAL_POINT]");
    end

    logic signed [PW-1:0] x_ext;
    logic signed [PW-1:0] y_clamp;
    logic signed [PW-1:0] sig_full;

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path can leave one unassigned and infer a latch.
        x_ext    = {{(PW-WIDTH){x[WIDTH-1]}}, x};
        y_clamp  = x_ext;
        sig_full = '0;
        factor   = '0;

        if (x[WIDTH-1]) begin
            y_clamp = '0;
        end else if (x_ext > ONE_P) begin
            y_clamp = ONE_P;
        end
        sig_full = (y_clamp * (ONE_P - y_clamp)) >>> DECIMAL_POINT;

        case (mode)
            ACT_RELU:     factor = x[WIDTH-1] ? '0 : ONE_F;
            ACT_LEAKY:    factor = x[WIDTH-1] ? LEAK_F : ONE_F;
            ACT_HARDTANH: factor = (x_ext >= NEG_ONE_P && x_ext <= ONE_P) ? ONE_F : '0;
            ACT_SIGMOID:  factor = FW'(sig_full);
            default:      factor = '0;
        endcase
    end

endmodule

// File: rtl/act_backward_sign.sv
// Streaming activation backward pass: gOut = sat(gIn * f'(xIn)) through a 3-stage
// pipeline (factor, product, shift+saturate) with one global stall on backpressure.
module act_backward_sign
    import act_backward_sign_pkg::*;
#(
    parameter int WIDTH                = 8,
    parameter int DECIMAL_POINT        = 5,
    parameter int NEGATIVE_SLOPE_SHIFT = 5,
    parameter int CNT_WIDTH            = 16
) (
    input  logic                        iClk,
    input  logic                        iRst,
    input  logic [1:0]                  mode,
    input  logic signed [WIDTH-1:0]     xIn,
    input  logic signed [WIDTH-1:0]     gIn,
    input  logic                        lastIn,
    input  logic                        inValid,
    output logic                        inReady,
    output logic signed [WIDTH-1:0]     gOut,
    output logic                        lastOut,
    output logic                        outValid,
    input  logic                        outReady,
    output logic [CNT_WIDTH-1:0]        beatCount
);

    localparam int FW = WIDTH + 1;
    localparam int PW = 2 * WIDTH;

    localparam logic signed [PW-1:0] SAT_MAX = PW'((1 <<< (WIDTH - 1)) - 1);
    localparam logic signed [PW-1:0] SAT_MIN = PW'(-(1 <<< (WIDTH - 1)));

    // All stages move together; the output register is the only stage that can block.
    logic advance;
    assign advance = !outValid || outReady;
    assign inReady = advance && iRst;

    logic signed [FW-1:0] factor;

    act_deriv_factor #(
        .WIDTH                (WIDTH),
        .DECIMAL_POINT        (DECIMAL_POINT),
        .NEGATIVE_SLOPE_SHIFT (NEGATIVE_SLOPE_SHIFT)
    ) u_factor (
        .mode   (act_mode_e'(mode)),
        .x      (xIn),
        .factor (factor)
    );

    logic                    s1_valid;
    logic signed [WIDTH-1:0] s1_g;
    logic signed [FW-1:0]    s1_f;
    logic                    s1_last;

    logic                    s2_valid;
    logic signed [PW-1:0]    s2_p;
    logic                    s2_last;

    logic signed [PW-1:0]    g_ext;
    logic signed [PW-1:0]    f_ext;
    logic signed [PW-1:0]    product;
    logic signed [PW-1:0]    r_shift;
    logic signed [WIDTH-1:0] r_sat;

    assign g_ext   = {{(PW-WIDTH){s1_g[WIDTH-1]}}, s1_g};
    assign f_ext   = {{(PW-FW){s1_f[FW-1]}}, s1_f};
    assign product = g_ext * f_ext;
    assign r_shift = s2_p >>> DECIMAL_POINT;

    always_comb begin
        r_sat = r_shift[WIDTH-1:0];
        if (r_shift > SAT_MAX) begin
            r_sat = SAT_MAX[WIDTH-1:0];
        end else if (r_shift < SAT_MIN) begin
            r_sat = SAT_MIN[WIDTH-1:0];
        end
    end

    // NOTE: payload registers carry no reset; the stage valid bits alone decide whether their contents mean anything.
    always_ff @(posedge iClk) begin
        if (advance) begin
            s1_g    <= gIn;
            s1_f    <= factor;
            s1_last <= lastIn;
            s2_p    <= product;
            s2_last <= s1_last;
        end
    end

    always_ff @(posedge iClk) begin
        // NOTE: non-blocking assignments make every register here sample the pre-edge values, as real flops do.
        if (!iRst) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            outValid  <= 1'b0;
            gOut      <= '0;
            lastOut   <= 1'b0;
            beatCount <= '0;
        end else begin
            if (outValid && outReady) begin
                beatCount <= beatCount + CNT_WIDTH'(1);
            end
            if (advance) begin
                s1_valid <= inValid;
                s2_valid <= s1_valid;
                outValid <= s2_valid;
                // Only real beats touch the output, so a bubble leaves the last result in place.
                if (s2_valid) begin
                    gOut    <= r_sat;
                    lastOut <= s2_last;
                end
            end
        end
    end

endmodule

// File: tb/tb_act_backward_sign.sv
// Self-checking bench for act_backward_sign: directed test-plan vectors, a randomised
// mixed-mode stream with backpressure, a fixed stall window, and reset with beats in flight.
module tb_act_backward_sign;
    import act_backward_sign_pkg::*;

    localparam int WIDTH = 8;
    localparam int DP    = 5;
    localparam int SH    = 5;
    localparam int CW    = 16;

    logic                    iClk = 1'b0;
    logic                    iRst;
    logic [1:0]              mode;
    logic signed [WIDTH-1:0] xIn;
    logic signed [WIDTH-1:0] gIn;
    logic                    lastIn;
    logic                    inValid;
    logic                    inReady;
    logic signed [WIDTH-1:0] gOut;
    logic                    lastOut;
    logic                    outValid;
    logic                    outReady;
    logic [CW-1:0]           beatCount;

    always #5 iClk = ~iClk;

    act_backward_sign #(
        .WIDTH                (WIDTH),
        .DECIMAL_POINT        (DP),
        .NEGATIVE_SLOPE_SHIFT (SH),
        .CNT_WIDTH            (CW)
    ) dut (
        .iClk      (iClk),
        .iRst      (iRst),
        .mode      (mode),
        .xIn       (xIn),
        .gIn       (gIn),
        .lastIn    (lastIn),
        .inValid   (inValid),
        .inReady   (inReady),
        .gOut      (gOut),
        .lastOut   (lastOut),
        .outValid  (outValid),
        .outReady  (outReady),
        .beatCount (beatCount)
    );

    typedef struct {
        int g;
        bit last;
        int acc;
        bit lat;
    } exp_t;

    typedef struct {
        int m;
        int x;
        int g;
        int res;
    } vec_t;

    exp_t sb[$];
    vec_t dir[12];
    int   n_vec  = 0;
    int   n_miss = 0;
    int   cyc    = 0;

    always @(posedge iClk) cyc++;

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model of one beat, written from the activation definitions.
    function automatic int model(input int m, input int x, input int g);
        int one, f, y, r;
        one = 1 << DP;
        case (m)
            0:       f = (x >= 0) ? one : 0;
            1:       f = (x >= 0) ? one : (one >>> SH);
            2:       f = (x >= -one && x <= one) ? one : 0;
            default: begin
                y = (x < 0) ? 0 : ((x > one) ? one : x);
                f = (y * (one - y)) >>> DP;
            end
        endcase
        r = (g * f) >>> DP;
        if (r > 127)  r = 127;
        if (r < -128) r = -128;
        return r;
    endfunction

    // Output side of the scoreboard: every delivered beat is popped and compared.
    always @(negedge iClk) begin : monitor
        exp_t e;
        if (iRst && outValid && outReady) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_miss++;
                $error("FAIL spurious_output: observed beat gOut=%0d, expected none", gOut);
            end else begin
                e = sb.pop_front();
                check("gOut", gOut, e.g);
                check("lastOut", lastOut, e.last);
                if (e.lat) check("latency", cyc - e.acc, 3);
            end
        end
    end

    task automatic send(input int m, input int x, input int g, input bit lst, input int res, input bit lat);
        exp_t e;
        bit   ok;
        ok = 1'b0;
        @(posedge iClk);
        #1;
        mode    = 2'(m);
        xIn     = 8'(x);
        gIn     = 8'(g);
        lastIn  = lst;
        inValid = 1'b1;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge iClk);
            if (inReady) begin
                e.g    = res;
                e.last = lst;
                e.acc  = cyc;
                e.lat  = lat;
                sb.push_back(e);
                ok = 1'b1;
            end
        end
        if (!ok) begin
            n_vec++;
            n_miss++;
            $error("FAIL accept_timeout: observed inReady low for 50 cycles, expected acceptance");
        end
    endtask

    task automatic drain();
        @(posedge iClk);
        #1;
        inValid = 1'b0;
        lastIn  = 1'b0;
        for (int t = 0; t < 100 && sb.size() != 0; t++) @(negedge iClk);
        check("drain_empty", sb.size(), 0);
    endtask

    task automatic apply_reset();
        @(posedge iClk);
        #1;
        iRst    = 1'b0;
        inValid = 1'b0;
        sb.delete();
        @(negedge iClk);
        check("rst_inReady", inReady, 0);
        @(negedge iClk);
        check("rst_outValid", outValid, 0);
        check("rst_gOut", gOut, 0);
        check("rst_lastOut", lastOut, 0);
        check("rst_beatCount", beatCount, 0);
        @(posedge iClk);
        #1;
        iRst = 1'b1;
    endtask

    // Streams n beats with either random or a fixed 4-cycle stall on outReady.
    task automatic stream(input int n, input bit rnd);
        exp_t e;
        int   k, held, m, x, g;
        bit   holding, lst;
        k = 0; held = 0; holding = 1'b0; m = 0; x = 0; g = 0; lst = 1'b0;
        for (int i = 0; i < 400 && (k < n || sb.size() != 0); i++) begin
            @(posedge iClk);
            #1;
            outReady = rnd ? ($urandom_range(0, 3) != 0) : !(i >= 3 && i < 7);
            if (k < n) begin
                if (rnd) begin
                    m = int'($urandom_range(0, 3));
                    x = int'($urandom_range(0, 255)) - 128;
                    g = int'($urandom_range(0, 255)) - 128;
                end else begin
                    m = k % 4;
                    x = k + 1;
                    g = 10 * (k + 1);
                end
                lst     = (k == n - 1);
                mode    = 2'(m);
                xIn     = 8'(x);
                gIn     = 8'(g);
                lastIn  = lst;
                inValid = 1'b1;
            end else begin
                inValid = 1'b0;
            end
            @(negedge iClk);
            if (outValid && !outReady) begin
                check("stall_inReady", inReady, 0);
                if (holding) check("stall_gOut_stable", gOut, held);
                held    = gOut;
                holding = 1'b1;
            end else begin
                holding = 1'b0;
            end
            if (inValid && inReady) begin
                e.g    = model(m, x, g);
                e.last = lst;
                e.acc  = cyc;
                e.lat  = 1'b0;
                sb.push_back(e);
                k++;
            end
        end
        outReady = 1'b1;
        inValid  = 1'b0;
        lastIn   = 1'b0;
        check("stream_sent", k, n);
        check("stream_drained", sb.size(), 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int c0;
        iRst     = 1'b0;
        mode     = 2'd0;
        xIn      = '0;
        gIn      = '0;
        lastIn   = 1'b0;
        inValid  = 1'b0;
        outReady = 1'b1;

        dir = '{
            '{0,  -3,  40,   0}, '{0,   0,  40,  40},
            '{1,  -1,  64,   2}, '{1,  -1, -64,  -2}, '{1,   5, -64, -64},
            '{2,  32,  20,  20}, '{2, -32,  20,  20}, '{2,  33,  20,   0}, '{2, -33,  20,   0},
            '{3,  16,  32,   8}, '{3,   0, 100,   0}, '{3,  40,  50,   0}
        };

        apply_reset();

        // Isolated relu beats: each result exactly 3 cycles after acceptance.
        send(dir[0].m, dir[0].x, dir[0].g, 1'b0, dir[0].res, 1'b1);
        drain();
        send(dir[1].m, dir[1].x, dir[1].g, 1'b1, dir[1].res, 1'b1);
        drain();

        // All directed vectors back-to-back, modes mixed in flight.
        c0 = cyc;
        for (int i = 0; i < 12; i++) begin
            send(dir[i].m, dir[i].x, dir[i].g, i == 11, dir[i].res, 1'b1);
        end
        check("throughput", cyc - c0, 12);
        drain();
        @(negedge iClk);
        check("beatCount_directed", beatCount, 14);

        // Randomised mixed-mode traffic with random backpressure.
        stream(40, 1'b1);
        @(negedge iClk);
        check("beatCount_random", beatCount, 54);

        // Fixed stall window from a clean counter.
        apply_reset();
        stream(6, 1'b0);
        @(negedge iClk);
        check("bp_beatCount", beatCount, 6);

        // Reset with three beats parked in the stalled pipeline.
        outReady = 1'b0;
        send(0, 1, 50, 1'b0, 50, 1'b0);
        send(1, 2, 51, 1'b0, 51, 1'b0);
        send(2, 3, 52, 1'b1, 52, 1'b0);
        apply_reset();
        outReady = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge iClk);
            check("post_rst_quiet", outValid, 0);
        end
        send(0, 1, 7, 1'b1, 7, 1'b1);
        drain();
        @(negedge iClk);
        check("beatCount_after_rst", beatCount, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
